// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder.
// State, op encoding and wait-counter width.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_e;

  localparam int CNT_W = 4;

  typedef struct packed {
    op_e         op;
    logic [31:0] wdata;
  } req_t;

  function automatic logic op_ok(
    input logic rd,
    input logic wr
  );
    return rd ^ wr;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data-memory responder.
// Synchronous write, combinational read, no reset.
module dmem_array #(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [DEPTH_W-1:0] idx,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  logic [31:0] mem [2**DEPTH_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: DM_CS/DM_R/DM_W strobe slave with
// programmable wait states and a one-cycle ready pulse.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_W     = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DM_CS,
  input  logic        DM_R,
  input  logic        DM_W,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  state_e             state_q;
  state_e             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  req_t               req_q;
  req_t               req_d;
  logic [DEPTH_W-1:0] idx_q;
  logic [DEPTH_W-1:0] idx_d;

  logic               legal;
  logic               zero_wait;
  logic               commit;
  req_t               cur;
  logic [DEPTH_W-1:0] cur_idx;
  logic [31:0]        mem_rd;
  logic               mem_we;

  logic [31:0]        rdata_d;
  logic               ready_d;
  logic               err_d;

  assign zero_wait = (WAIT_CYCLES == 0);

  assign legal = (addr[1:0] == 2'b00)
              && (addr[31:DEPTH_W+2] == '0)
              && op_ok(DM_R, DM_W);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    idx_d   = idx_q;
    commit  = 1'b0;
    cur     = req_q;
    cur_idx = idx_q;
    rdata_d = rdata;
    ready_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (DM_CS) begin
          req_d.op    = DM_W ? OP_WR : OP_RD;
          req_d.wdata = wdata;
          idx_d       = addr[DEPTH_W+1:2];
          // zero-wait commit uses the live request, not the latch
          cur         = req_d;
          cur_idx     = idx_d;
          unique case (1'b1)
            !legal: begin
              state_d = DONE;
              ready_d = 1'b1;
              err_d   = 1'b1;
              rdata_d = '0;
            end
            legal && zero_wait: begin
              state_d = DONE;
              commit  = 1'b1;
              ready_d = 1'b1;
            end
            default: begin
              state_d = WAIT;
              cnt_d   = CNT_W'(WAIT_CYCLES - 1);
            end
          endcase
        end
      end
      WAIT: begin
        unique case (1'b1)
          !DM_CS: begin
            state_d = IDLE;
          end
          cnt_q == '0: begin
            state_d = DONE;
            commit  = 1'b1;
            ready_d = 1'b1;
          end
          default: begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        endcase
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (commit && cur.op == OP_RD) begin
      rdata_d = mem_rd;
    end
  end

  // a write must never land while reset is held
  assign mem_we = commit && (cur.op == OP_WR) && reset;

  dmem_array #(
    .DEPTH_W (DEPTH_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (cur_idx),
    .wdata (cur.wdata),
    .rdata (mem_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      idx_q   <= '0;
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
      rdata   <= rdata_d;
      ready   <= ready_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states)
// against a transaction-level model of completions.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs   [2];
  logic        rd   [2];
  logic        wr   [2];
  logic [31:0] ad   [2];
  logic [31:0] wd   [2];
  logic [31:0] rdat [2];
  logic        rdy  [2];
  logic        er   [2];

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(
    .DEPTH_W     (8),
    .WAIT_CYCLES (2)
  ) u_w2 (
    .clk   (clk),
    .reset (reset),
    .DM_CS (cs[0]),
    .DM_R  (rd[0]),
    .DM_W  (wr[0]),
    .addr  (ad[0]),
    .wdata (wd[0]),
    .rdata (rdat[0]),
    .ready (rdy[0]),
    .err   (er[0])
  );

  dmem_responder #(
    .DEPTH_W     (8),
    .WAIT_CYCLES (0)
  ) u_w0 (
    .clk   (clk),
    .reset (reset),
    .DM_CS (cs[1]),
    .DM_R  (rd[1]),
    .DM_W  (wr[1]),
    .addr  (ad[1]),
    .wdata (wd[1]),
    .rdata (rdat[1]),
    .ready (rdy[1]),
    .err   (er[1])
  );

  // Model: each accepted request becomes one completion event,
  // keyed by (completion cycle, instance).
  typedef struct {
    bit          err;
    bit          wr;
    int          idx;
    logic [31:0] wd;
  } ev_t;

  ev_t         ev     [int];
  logic [31:0] mm     [int];
  logic [31:0] exp_rd [2];

  function automatic void model_req(input int d, input bit r,
                                    input bit w,
                                    input logic [31:0] a,
                                    input logic [31:0] dat);
    ev_t e;
    int  lat;
    lat   = (d == 0) ? 3 : 1;
    e.err = (a[1:0] != 2'b00) || (a[31:10] != 22'd0) || (r == w);
    e.wr  = w;
    e.idx = int'(a[9:2]);
    e.wd  = dat;
    if (e.err) lat = 1;
    ev[(cyc + lat) * 2 + d] = e;
  endfunction

  function automatic void model_abort(input int d, input int t);
    ev.delete((t + 3) * 2 + d);
  endfunction

  function automatic void model_reset();
    ev.delete();
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      ev_t e;
      int  key;
      bit  rdy_e;
      bit  err_e;
      key   = cyc * 2 + d;
      rdy_e = 1'b0;
      err_e = 1'b0;
      if (ev.exists(key)) begin
        e     = ev[key];
        ev.delete(key);
        rdy_e = 1'b1;
        err_e = e.err;
        if (e.err) exp_rd[d] = 32'h0;
        else if (e.wr) mm[e.idx * 2 + d] = e.wd;
        else if (mm.exists(e.idx * 2 + d)) exp_rd[d] = mm[e.idx * 2 + d];
        else exp_rd[d] = 32'hx;
      end
      check($sformatf("m_ready%0d", d), 32'(rdy[d]), 32'(rdy_e));
      if (rdy_e) check($sformatf("m_err%0d", d), 32'(er[d]), 32'(err_e));
      check($sformatf("m_rdata%0d", d), rdat[d], exp_rd[d]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int d, input bit r, input bit w,
                         input logic [31:0] a,
                         input logic [31:0] dat);
    cs[d] = 1'b1;
    rd[d] = r;
    wr[d] = w;
    ad[d] = a;
    wd[d] = dat;
    model_req(d, r, w, a, dat);
  endtask

  task automatic access(input int d, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] dat,
                        input int lat, input bit e_err, input bit chk,
                        input logic [31:0] e_rd, input string nm);
    set_req(d, r, w, a, dat);
    for (int i = 1; i <= lat; i++) begin
      tick();
      if (i == 1) begin
        ad[d] = $urandom;
        wd[d] = $urandom;
      end
      if (i < lat) check({nm, "_early"}, 32'(rdy[d]), 32'd0);
    end
    check({nm, "_ready"}, 32'(rdy[d]), 32'd1);
    check({nm, "_err"}, 32'(er[d]), 32'(e_err));
    if (chk) check({nm, "_rdata"}, rdat[d], e_rd);
    tick();
    cs[d] = 1'b0;
    check({nm, "_pulse"}, 32'(rdy[d]), 32'd0);
  endtask

  initial begin
    int t;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cs[d] = 1'b0;
      rd[d] = 1'b0;
      wr[d] = 1'b0;
      ad[d] = 32'h0;
      wd[d] = 32'h0;
    end
    model_reset();
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 32'(rdy[d]), 32'd0);
      check("rst_err", 32'(er[d]), 32'd0);
      check("rst_rdata", rdat[d], 32'h0);
    end
    reset = 1'b1;
    tick();

    access(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 3, 0, 0, 0, "w10");
    access(0, 1, 0, 32'h10, 32'h0, 3, 0, 1, 32'hDEAD_BEEF, "r10");
    access(0, 0, 1, 32'h20, 32'h1111_1111, 3, 0, 0, 0, "w20");
    access(0, 0, 1, 32'h30, 32'h2222_2222, 3, 0, 0, 0, "w30");
    access(0, 0, 1, 32'h40, 32'h3333_3333, 3, 0, 0, 0, "w40");

    access(0, 1, 0, 32'h6, 32'h0, 1, 1, 1, 32'h0, "ill_align");
    access(0, 1, 0, 32'h400, 32'h0, 1, 1, 1, 32'h0, "ill_range");
    access(0, 1, 1, 32'h10, 32'hFFFF_FFFF, 1, 1, 1, 32'h0, "ill_both");
    access(0, 0, 0, 32'h10, 32'hFFFF_FFFF, 1, 1, 1, 32'h0, "ill_none");
    access(0, 1, 0, 32'h10, 32'h0, 3, 0, 1, 32'hDEAD_BEEF, "r10_kept");

    set_req(0, 0, 1, 32'h20, 32'hAAAA_AAAA);
    t = cyc;
    tick();
    cs[0] = 1'b0;
    model_abort(0, t);
    tick();
    tick();
    check("abort_ready", 32'(rdy[0]), 32'd0);
    tick();
    access(0, 1, 0, 32'h20, 32'h0, 3, 0, 1, 32'h1111_1111, "r20_abort");

    set_req(0, 0, 1, 32'h30, 32'h5555_5555);
    tick();
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_async_ready", 32'(rdy[0]), 32'd0);
    check("rst_async_err", 32'(er[0]), 32'd0);
    check("rst_async_rdata", rdat[0], 32'h0);
    cs[0] = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    access(0, 1, 0, 32'h30, 32'h0, 3, 0, 1, 32'h2222_2222, "r30_rst");

    set_req(0, 1, 0, 32'h40, 32'h0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) model_req(0, 1, 0, 32'h40, 32'h0);
      tick();
      tick();
      check("tp_gap", 32'(rdy[0]), 32'd0);
      tick();
      check("tp_ready", 32'(rdy[0]), 32'd1);
      check("tp_rdata", rdat[0], 32'h3333_3333);
      tick();
      check("tp_width", 32'(rdy[0]), 32'd0);
    end
    cs[0] = 1'b0;
    tick();

    access(1, 0, 1, 32'h0, 32'h1234_5678, 1, 0, 0, 0, "z_w0");
    access(1, 1, 0, 32'h0, 32'h0, 1, 0, 1, 32'h1234_5678, "z_r0");
    access(1, 1, 1, 32'h0, 32'h0, 1, 1, 1, 32'h0, "z_ill");
    access(1, 1, 0, 32'h0, 32'h0, 1, 0, 1, 32'h1234_5678, "z_r0b");

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
